// File: rtl/serial_pkg.sv
// Shared types and defaults for the serial transmit scheduler.
package serial_pkg;

  localparam int SERIAL_BAUD_DIV   = 5209;
  localparam int SERIAL_FRAME_BITS = 12;

  typedef enum logic [1:0] {
    DRAIN,
    IDLE,
    START,
    WAIT
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] idx
);

  localparam int IW = $clog2(N);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/serial_tx_sched.sv
// Shares one 8N1 transmitter between NREQ byte sources, holding
// tx_data steady for a whole reserved frame after each txe pulse.
module serial_tx_sched
  import serial_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int BAUD_DIV   = SERIAL_BAUD_DIV,
  parameter int FRAME_BITS = SERIAL_FRAME_BITS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [8*NREQ-1:0]       req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [7:0]              tx_data,
  output logic                    tx_txe,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] grant_id
);

  localparam int IW           = $clog2(NREQ);
  localparam int FRAME_CYCLES = FRAME_BITS * BAUD_DIV;
  localparam int CW           = $clog2(FRAME_CYCLES);
  localparam logic [CW-1:0] CNT_LOAD = CW'(FRAME_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [7:0]      data_q, data_d;
  logic            txe_q, txe_d;
  logic [IW-1:0]   gid_q, gid_d;
  logic [NREQ-1:0] arb_gnt;
  logic [IW-1:0]   arb_idx;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    data_d    = data_q;
    txe_d     = 1'b0;
    gid_d     = gid_q;
    req_ready = '0;
    unique case (state_q)
      // The reset cycle itself already counts toward the drain time.
      DRAIN: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) state_d = IDLE;
      end
      IDLE: begin
        req_ready = arb_gnt;
        if (|arb_gnt) begin
          data_d  = req_data[8*int'(arb_idx) +: 8];
          gid_d   = arb_idx;
          ptr_d   = (arb_idx == IW'(NREQ - 1)) ? '0 : arb_idx + IW'(1);
          txe_d   = 1'b1;
          state_d = START;
        end
      end
      START: begin
        cnt_d   = CNT_LOAD;
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= DRAIN;
      cnt_q   <= CNT_LOAD;
      ptr_q   <= '0;
      data_q  <= 8'h00;
      txe_q   <= 1'b0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      txe_q   <= txe_d;
      gid_q   <= gid_d;
    end
  end

  assign tx_data  = data_q;
  assign tx_txe   = txe_q;
  assign grant_id = gid_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_serial_tx_sched.sv
// Bench for serial_tx_sched: timestamp-based scheduler model plus
// an 8N1 line model/decoder on a second, slower-baud instance.
module tb_serial_tx_sched;

  localparam int N   = 4;
  localparam int FC  = 12;
  localparam int D2  = 16;
  localparam int FB2 = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic [7:0]     tx_data;
  logic           tx_txe;
  logic           busy;
  logic [1:0]     grant_id;

  serial_tx_sched #(.NREQ(N), .BAUD_DIV(4), .FRAME_BITS(3)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_data(tx_data), .tx_txe(tx_txe),
    .busy(busy), .grant_id(grant_id)
  );

  logic           rst2 = 1'b1;
  logic [N-1:0]   v2 = '0;
  logic [8*N-1:0] d2 = '0;
  logic [N-1:0]   rdy2;
  logic [7:0]     data2;
  logic           txe2;
  logic           busy2;
  logic [1:0]     gid2;

  serial_tx_sched #(.NREQ(N), .BAUD_DIV(D2), .FRAME_BITS(FB2)) dut2 (
    .clk(clk), .rst(rst2), .req_valid(v2), .req_data(d2),
    .req_ready(rdy2), .tx_data(data2), .tx_txe(txe2),
    .busy(busy2), .grant_id(gid2)
  );

  int vectors = 0;
  int errors  = 0;

  // Scheduler model: everything derived from transfer timestamps.
  int         p = 0;
  int         free_at = 0;
  int         txe_at = -100;
  int         m_ptr = 0;
  int         m_gid = 0;
  logic [7:0] m_data = 8'h00;

  int cg[$];
  int ct[$];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++)
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    if (p >= free_at) begin
      w = pick(req_valid, m_ptr);
      if (w >= 0) r[w] = 1'b1;
    end
    return r;
  endfunction

  task automatic tick();
    int w;
    @(posedge clk);
    if (rst) begin
      p = 1; free_at = FC; txe_at = -100;
      m_ptr = 0; m_gid = 0; m_data = 8'h00;
    end else begin
      w = (p >= free_at) ? pick(req_valid, m_ptr) : -1;
      if (w >= 0) begin
        m_data  = req_data[8*w +: 8];
        m_gid   = w;
        m_ptr   = (w + 1) % N;
        txe_at  = p + 1;
        free_at = p + 2 + FC;
      end
      p++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic collect(input int n, input int maxc);
    cg.delete();
    ct.delete();
    for (int c = 0; c < maxc && cg.size() < n; c++) begin
      #1;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          cg.push_back(i);
          ct.push_back(p);
        end
      tick();
    end
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_data  = '0;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0041;
    #1;
    vectors++;
    if ({tx_data, tx_txe, busy, grant_id, req_ready} !== {8'h00, 1'b0, 1'b1, 2'd0, 4'd0}) begin
      errors++;
      $display("FAIL reset_state: got data=%h txe=%b busy=%b gid=%0d rdy=%b want 00 0 1 0 0000",
               tx_data, tx_txe, busy, grant_id, req_ready);
    end
    for (int c = 1; c <= 11; c++) begin
      vectors++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL drain_ready c%0d: got %b want 0000", c, req_ready);
      end
      tick();
      #1;
    end
    vectors++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL first_grant c12: got %b want 0001", req_ready);
    end
    tick();
    vectors++;
    if ({tx_txe, tx_data, grant_id} !== {1'b1, 8'h41, 2'd0}) begin
      errors++;
      $display("FAIL first_start: got txe=%b data=%h gid=%0d want 1 41 0", tx_txe, tx_data, grant_id);
    end
    tick();
    vectors++;
    if ({tx_txe, tx_data} !== {1'b0, 8'h41}) begin
      errors++;
      $display("FAIL txe_one_cycle: got txe=%b data=%h want 0 41", tx_txe, tx_data);
    end
  endtask

  task automatic test_rr_pair();
    int g[$];
    int t[$];
    int want[4] = '{0, 2, 0, 2};
    req_valid = '0;
    do_reset();
    req_valid = 4'b0101;
    req_data  = 32'h0032_0010;
    for (int c = 0; c < 80 && g.size() < 4; c++) begin
      #1;
      for (int i = 0; i < N; i++)
        if (req_ready[i] && req_valid[i]) begin
          g.push_back(i);
          t.push_back(p);
        end
      vectors++;
      if (tx_data !== m_data || (tx_txe && grant_id !== 2'(m_gid))) begin
        errors++;
        $display("FAIL pair_hold p%0d: got data=%h gid=%0d want %h %0d", p, tx_data, grant_id, m_data, m_gid);
      end
      tick();
    end
    vectors++;
    if (g.size() != 4) begin
      errors++;
      $display("FAIL pair_count: got %0d transfers want 4", g.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (g[k] != want[k]) begin
          errors++;
          $display("FAIL pair_order[%0d]: got %0d want %0d", k, g[k], want[k]);
        end
        if (k > 0) begin
          vectors++;
          if (t[k] - t[k-1] != FC + 2) begin
            errors++;
            $display("FAIL pair_spacing[%0d]: got %0d want %0d", k, t[k] - t[k-1], FC + 2);
          end
        end
      end
    end
  endtask

  task automatic test_all_four();
    int want[4] = '{3, 0, 1, 2};
    req_valid = '0;
    do_reset();
    req_valid = 4'b0100;
    req_data  = 32'hD3_C2_B1_A0;
    collect(1, 20);
    req_valid = 4'b1111;
    collect(4, 100);
    vectors++;
    if (cg.size() != 4) begin
      errors++;
      $display("FAIL four_count: got %0d want 4", cg.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (cg[k] != want[k]) begin
          errors++;
          $display("FAIL four_order[%0d]: got %0d want %0d", k, cg[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_pulse_wait();
    int pulses;
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_005A;
    collect(1, 20);
    req_valid = '0;
    tick(); tick(); tick();
    req_valid = 4'b0010;
    req_data  = 32'h0000_EE5A;
    #1;
    vectors++;
    if (req_ready !== 4'b0000 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL pulse_wait: got rdy=%b data=%h want 0000 5a", req_ready, tx_data);
    end
    tick();
    req_valid = '0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (tx_txe) pulses++;
      tick();
    end
    vectors++;
    if (pulses != 0 || tx_data !== 8'h5A) begin
      errors++;
      $display("FAIL pulse_no_xfer: got txe_count=%0d data=%h want 0 5a", pulses, tx_data);
    end
  endtask

  task automatic test_mid_reset();
    req_valid = '0;
    do_reset();
    req_valid = 4'b0001;
    req_data  = 32'h0000_0077;
    collect(1, 20);
    for (int c = 0; c < 6; c++) tick();
    vectors++;
    if (tx_data !== 8'h77 || busy !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset: got data=%h busy=%b want 77 1", tx_data, busy);
    end
    do_reset();
    #1;
    vectors++;
    if (tx_data !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset: got data=%h busy=%b want 00 1", tx_data, busy);
    end
    for (int c = 1; c <= 12; c++) begin
      vectors++;
      if (tx_txe !== 1'b0) begin
        errors++;
        $display("FAIL mid_reset_txe c%0d: got %b want 0", c, tx_txe);
      end
      tick();
    end
    vectors++;
    if (tx_txe !== 1'b1 || tx_data !== 8'h77) begin
      errors++;
      $display("FAIL post_drain_start: got txe=%b data=%h want 1 77", tx_txe, tx_data);
    end
  endtask

  task automatic test_random();
    req_valid = '0;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      rst       = ($urandom_range(0, 59) == 0);
      req_valid = N'($urandom_range(0, 15)) & N'($urandom_range(0, 15));
      req_data  = $urandom;
      #1;
      if (!rst) begin
        vectors++;
        if (req_ready !== exp_ready() || tx_txe !== (p == txe_at) ||
            busy !== (p < free_at) || tx_data !== m_data || grant_id !== 2'(m_gid)) begin
          errors++;
          $display("FAIL random p%0d: got rdy=%b txe=%b busy=%b data=%h gid=%0d want %b %b %b %h %0d",
                   p, req_ready, tx_txe, busy, tx_data, grant_id,
                   exp_ready(), (p == txe_at), (p < free_at), m_data, m_gid);
        end
      end
      tick();
    end
    rst = 1'b0;
  endtask

  // 8N1 transmitter with no reset, sampling data live at each bit,
  // plus a decoder reading the line once per baud tick.
  int         bcnt = 0;
  int         ph = 0;
  int         ferr = 0;
  int         ovl = 0;
  logic       pend = 1'b0;
  logic       line = 1'b1;
  logic [7:0] rxb = 8'h00;
  logic [7:0] rxq[$];

  always @(posedge clk) begin
    bcnt <= (bcnt == D2 - 1) ? 0 : bcnt + 1;
    if (txe2 === 1'b1) begin
      if (pend || ph != 0) ovl <= ovl + 1;
      pend <= 1'b1;
    end
    if (bcnt == D2 - 1) begin
      if (ph == 0) begin
        if (pend) begin
          line <= 1'b0;
          ph   <= 1;
          pend <= 1'b0;
        end
      end else if (ph <= 8) begin
        if (ph == 1) begin
          if (line !== 1'b0) ferr <= ferr + 1;
        end else begin
          rxb[ph-2] <= line;
        end
        line <= data2[ph-1];
        ph   <= ph + 1;
      end else if (ph == 9) begin
        rxb[7] <= line;
        line   <= 1'b1;
        ph     <= 10;
      end else begin
        if (line !== 1'b1) ferr <= ferr + 1;
        rxq.push_back(rxb);
        ph <= 0;
      end
    end
  end

  task automatic test_serial();
    logic [7:0]   want[3] = '{8'h00, 8'hFF, 8'h55};
    logic [N-1:0] x;
    rst2 = 1'b1;
    repeat (2) @(negedge clk);
    rst2 = 1'b0;
    d2   = {8'h99, 8'h55, 8'hFF, 8'h00};
    v2   = 4'b0111;
    for (int c = 0; c < 3000 && rxq.size() < 3; c++) begin
      #1;
      x = rdy2 & v2;
      @(negedge clk);
      v2 = v2 & ~x;
    end
    vectors++;
    if (rxq.size() != 3) begin
      errors++;
      $display("FAIL serial_count: got %0d bytes want 3", rxq.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        vectors++;
        if (rxq[k] !== want[k]) begin
          errors++;
          $display("FAIL serial_byte[%0d]: got %h want %h", k, rxq[k], want[k]);
        end
      end
    end
    vectors++;
    if (ferr != 0 || ovl != 0) begin
      errors++;
      $display("FAIL serial_framing: got frame_err=%0d overlap=%0d want 0 0", ferr, ovl);
    end
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    @(negedge clk);
    test_reset();
    test_rr_pair();
    test_all_four();
    test_pulse_wait();
    test_mid_reset();
    test_random();
    test_serial();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
